// File: rtl/dsdac_pkg.sv
// Shared constants and helpers for the dsdac_mod delta-sigma modulator.
// Optional dither is enabled by defining DSDAC_DITHER_EN.
package dsdac_pkg;

    localparam int ORDER_MIN = 1;
    localparam int ORDER_MAX = 2;

    localparam int unsigned LFSR_W        = 16;
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;
    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR map to bits 0,2,3,5
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    localparam int unsigned SAT_MAXW = 64;

    // Clamp v to the signed range of an aw-bit two's complement number
    function automatic logic signed [SAT_MAXW-1:0] sat(
        input logic signed [SAT_MAXW-1:0] v,
        input int unsigned                aw
    );
        logic signed [SAT_MAXW-1:0] hi;
        logic signed [SAT_MAXW-1:0] lo;
        hi = (SAT_MAXW'(1) << (aw - 1)) - SAT_MAXW'(1);
        lo = ~hi;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/dsdac_channel.sv
// One modulator channel: sample hold, 1st/2nd order saturating loop, sticky clip.
// DSDAC_DITHER_EN adds a per-channel LFSR that injects +/-1 LSB into the first sum.
module dsdac_channel
    import dsdac_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int          ORDER = 2,
    parameter int unsigned GUARD = 4,
    parameter int unsigned CH    = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         sample_valid,
    input  logic [W-1:0] sample,
    input  logic         clip_clr,
    output logic         bit_o,
    output logic         clip_o
);

    localparam int unsigned AW = W + GUARD + 1;
    localparam int unsigned SW = AW + 2;

    localparam logic signed [SW-1:0] HALF     = {{(SW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
    localparam logic        [W-1:0]  HOLD_RST = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0]           hold_q, hold_d;
    logic signed [AW-1:0]   acc1_q, acc1_d;
    logic signed [AW-1:0]   acc2_q, acc2_d;
    logic                   bit_q, bit_d;
    logic                   clip_q, clip_d;

    logic signed [SW-1:0]   xs, fb, dith;
    logic signed [SW-1:0]   s1, s1_sat, s2, s2_sat;
    logic                   clamp;

`ifdef DSDAC_DITHER_EN
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = en ? {^(lfsr_q & LFSR_TAP_MASK), lfsr_q[LFSR_W-1:1]} : lfsr_q;
        dith   = lfsr_q[0] ? SW'(1) : '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= LFSR_SEED ^ 16'(CH);
        else        lfsr_q <= lfsr_d;
    end
`else
    always_comb dith = '0;
`endif

    always_comb begin
        hold_d = sample_valid ? sample : hold_q;
        // MSB flip turns offset-binary into two's complement; extend with the flipped sign
        xs     = {{(SW-W+1){~hold_q[W-1]}}, hold_q[W-2:0]};
        fb     = bit_q ? HALF : -HALF;
        s1     = {{2{acc1_q[AW-1]}}, acc1_q} + xs - fb + dith;
        s1_sat = SW'(sat(SAT_MAXW'(s1), AW));
        s2     = {{2{acc2_q[AW-1]}}, acc2_q} + s1_sat - fb;
        s2_sat = SW'(sat(SAT_MAXW'(s2), AW));

        acc1_d = acc1_q;
        acc2_d = acc2_q;
        bit_d  = bit_q;
        clamp  = 1'b0;
        if (en) begin
            acc1_d = s1_sat[AW-1:0];
            if (ORDER == 2) begin
                acc2_d = s2_sat[AW-1:0];
                bit_d  = ~s2[SW-1];
                clamp  = (s1_sat != s1) || (s2_sat != s2);
            end else begin
                bit_d  = ~s1[SW-1];
                clamp  = (s1_sat != s1);
            end
        end
        clip_d = clamp | (clip_q & ~clip_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= HOLD_RST;
            acc1_q <= '0;
            acc2_q <= '0;
            bit_q  <= 1'b0;
            clip_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            acc1_q <= acc1_d;
            acc2_q <= acc2_d;
            bit_q  <= bit_d;
            clip_q <= clip_d;
        end
    end

    assign bit_o  = bit_q;
    assign clip_o = clip_q;

endmodule

// File: rtl/dsdac_mod.sv
// Multi-channel delta-sigma DAC modulator: NCH independent dsdac_channel instances.
// Define DSDAC_DITHER_EN to enable per-channel LFSR dither.
module dsdac_mod
    import dsdac_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned NCH   = 2,
    parameter int          ORDER = 2,
    parameter int unsigned GUARD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sample_valid,
    input  logic [NCH*W-1:0] signal,
    input  logic             clip_clr,
    output logic [NCH-1:0]   bitstream,
    output logic [NCH-1:0]   clip
);

    if (ORDER < ORDER_MIN || ORDER > ORDER_MAX) begin : g_bad_order
        $error("dsdac_mod: ORDER must be 1 or 2");
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        dsdac_channel #(
            .W     (W),
            .ORDER (ORDER),
            .GUARD (GUARD),
            .CH    (c)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .en           (en),
            .sample_valid (sample_valid),
            .sample       (signal[c*W +: W]),
            .clip_clr     (clip_clr),
            .bit_o        (bitstream[c]),
            .clip_o       (clip[c])
        );
    end

endmodule

// File: tb/tb_dsdac_mod.sv
// Scoreboard bench for dsdac_mod: one ORDER=1 and one ORDER=2 instance share stimulus.
module tb_dsdac_mod;

    localparam longint HALF = 32768;
    localparam longint AHI  = 1048575;
    localparam longint ALO  = -1048576;

    logic        clk = 1'b0;
    logic        rst_n, en, sample_valid, clip_clr;
    logic [31:0] signal;
    logic [1:0]  bs1, cl1, bs2, cl2;

    always #5 clk = ~clk;

    dsdac_mod #(.W(16), .NCH(2), .ORDER(1), .GUARD(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .sample_valid(sample_valid),
        .signal(signal), .clip_clr(clip_clr), .bitstream(bs1), .clip(cl1)
    );
    dsdac_mod #(.W(16), .NCH(2), .ORDER(2), .GUARD(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .sample_valid(sample_valid),
        .signal(signal), .clip_clr(clip_clr), .bitstream(bs2), .clip(cl2)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [1:0] bs1, cl1, bs2, cl2;
    } exp_t;
    exp_t exp_q[$];

    // Reference state: index [loop order - 1][channel]
    longint m_acc1[2][2], m_acc2[2][2];
    bit     m_bs[2][2], m_clip[2][2];
    longint m_hold[2];
    bit     m_clamp20;
    int     ones1[2], ones2[2];

    function automatic longint satf(longint v);
        if (v > AHI) return AHI;
        if (v < ALO) return ALO;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endtask

    task automatic chk_range(input string nm, input int v, input int lo, input int hi);
        tests++;
        if (v < lo || v > hi) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d..%0d", nm, $time, v, lo, hi);
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < 2; o++)
            for (int c = 0; c < 2; c++) begin
                m_acc1[o][c] = 0; m_acc2[o][c] = 0;
                m_bs[o][c] = 0;   m_clip[o][c] = 0;
            end
        m_hold[0] = HALF;
        m_hold[1] = HALF;
        m_clamp20 = 0;
    endtask

    task automatic model_step(input bit e, input bit v, input logic [15:0] sg0,
                              input logic [15:0] sg1, input bit clr);
        longint xs, fb, s1, a1, s2, a2;
        bit cl;
        for (int o = 0; o < 2; o++)
            for (int c = 0; c < 2; c++) begin
                cl = 0;
                if (e) begin
                    xs = m_hold[c] - HALF;
                    fb = m_bs[o][c] ? HALF : -HALF;
                    s1 = m_acc1[o][c] + xs - fb;
                    a1 = satf(s1);
                    cl = (a1 != s1);
                    m_acc1[o][c] = a1;
                    if (o == 0) begin
                        m_bs[o][c] = (s1 >= 0);
                    end else begin
                        s2 = m_acc2[o][c] + a1 - fb;
                        a2 = satf(s2);
                        cl = cl || (a2 != s2);
                        m_acc2[o][c] = a2;
                        m_bs[o][c] = (s2 >= 0);
                    end
                end
                if (cl)       m_clip[o][c] = 1;
                else if (clr) m_clip[o][c] = 0;
                if (o == 1 && c == 0) m_clamp20 = cl;
            end
        if (v) begin
            m_hold[0] = sg0;
            m_hold[1] = sg1;
        end
    endtask

    // One clock: drive at negedge, predict, return after the edge has been checked
    task automatic cycle(input bit e, input bit v, input logic [15:0] sg0,
                         input logic [15:0] sg1, input bit clr);
        exp_t x;
        @(negedge clk);
        en = e; sample_valid = v; signal = {sg1, sg0}; clip_clr = clr;
        model_step(e, v, sg0, sg1, clr);
        x.bs1 = {m_bs[0][1], m_bs[0][0]};
        x.cl1 = {m_clip[0][1], m_clip[0][0]};
        x.bs2 = {m_bs[1][1], m_bs[1][0]};
        x.cl2 = {m_clip[1][1], m_clip[1][0]};
        exp_q.push_back(x);
        @(posedge clk);
        #2;
        for (int c = 0; c < 2; c++) begin
            ones1[c] += int'(bs1[c]);
            ones2[c] += int'(bs2[c]);
        end
    endtask

    task automatic clear_counts();
        ones1 = '{0, 0};
        ones2 = '{0, 0};
    endtask

    task automatic check_mid_pattern(input string nm);
        logic [5:0] pat;
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, 16'h8000, 16'h8000, 0);
            pat[5-i] = bs1[0];
        end
        chk(nm, 32'(pat), 32'b110101);
    endtask

    // Monitor: every clock edge that had stimulus gets its prediction popped and compared
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("bitstream_ord1", 32'(bs1), 32'(e.bs1));
            chk("clip_ord1",      32'(cl1), 32'(e.cl1));
            chk("bitstream_ord2", 32'(bs2), 32'(e.bs2));
            chk("clip_ord2",      32'(cl2), 32'(e.cl2));
        end
    end

    initial begin
        logic [31:0] hist;
        int viol, quiet;
        logic [15:0] r0, r1;

        rst_n = 1'b0; en = 1'b0; sample_valid = 1'b0; clip_clr = 1'b0;
        signal = {16'h8000, 16'h8000};
        model_reset();
        clear_counts();
        repeat (3) @(negedge clk);
        chk("rst_bitstream1", 32'(bs1), 0);
        chk("rst_clip1",      32'(cl1), 0);
        chk("rst_bitstream2", 32'(bs2), 0);
        chk("rst_clip2",      32'(cl2), 0);
        rst_n = 1'b1;

        // Midscale ORDER=1 start-up sequence and density
        check_mid_pattern("mid_pattern");
        clear_counts();
        repeat (1024) cycle(1, 0, 16'h8000, 16'h8000, 0);
        chk_range("mid_ones1024", ones1[0], 511, 513);

        // 25% input on the first-order loop: one 1 in every 4, period 4
        cycle(1, 1, 16'h4000, 16'h4000, 0);
        repeat (16) cycle(1, 0, 16'h4000, 16'h4000, 0);
        for (int i = 0; i < 32; i++) begin
            cycle(1, 0, 16'h4000, 16'h4000, 0);
            hist[i] = bs1[0];
        end
        viol = 0;
        for (int i = 4; i < 32; i++) if (hist[i] != hist[i-4]) viol++;
        for (int i = 0; i < 32; i += 4) if ((32'(hist[i]) + hist[i+1] + hist[i+2] + hist[i+3]) != 1) viol++;
        chk("q4000_pattern", 32'(viol), 0);

        // Second-order densities at 1/8 and 7/8 scale
        cycle(1, 1, 16'h2000, 16'hE000, 0);
        clear_counts();
        repeat (8192) cycle(1, 0, 16'h2000, 16'hE000, 0);
        chk_range("ord2_ones_ch0", ones2[0], 1016, 1032);
        chk_range("ord2_ones_ch1", ones2[1], 7160, 7176);
        chk("ord2_noclip", 32'(cl2), 0);

        // Full-scale input overloads the second-order loop
        cycle(1, 1, 16'hFFFF, 16'h8000, 0);
        repeat (4096) cycle(1, 0, 16'hFFFF, 16'h8000, 0);
        chk("full_clip_set", 32'(cl2[0]), 1);
        cycle(1, 0, 16'hFFFF, 16'h8000, 1);
        if (m_clamp20) chk("clip_set_beats_clr", 32'(cl2[0]), 1);
        cycle(1, 1, 16'h8000, 16'h8000, 0);
        quiet = 0;
        for (int k = 0; k < 2000 && quiet < 64; k++) begin
            cycle(1, 0, 16'h8000, 16'h8000, 0);
            quiet = m_clamp20 ? 0 : quiet + 1;
        end
        chk_range("clamp_recovery", quiet, 64, 64);
        cycle(1, 0, 16'h8000, 16'h8000, 1);
        chk("clip_cleared", 32'(cl2[0]), 32'(m_clamp20));

        // Freeze for 100 cycles mid-run, then resume
        cycle(1, 1, 16'h5A5A, 16'h3333, 0);
        repeat (50)  cycle(1, 0, 16'h5A5A, 16'h3333, 0);
        repeat (100) cycle(0, 0, 16'h5A5A, 16'h3333, 0);
        repeat (50)  cycle(1, 0, 16'h5A5A, 16'h3333, 0);

        // Randomised enables, loads and clears
        r0 = 16'h8000; r1 = 16'h8000;
        for (int i = 0; i < 3000; i++) begin
            bit e, v, c;
            e = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 15) == 0);
            c = ($urandom_range(0, 31) == 0);
            if (v) begin
                if ($urandom_range(0, 7) == 0) begin
                    r0 = 16'($urandom); r1 = 16'($urandom);
                end else begin
                    r0 = 16'($urandom_range(16'h1000, 16'hF000));
                    r1 = 16'($urandom_range(16'h1000, 16'hF000));
                end
            end
            cycle(e, v, r0, r1, c);
        end

        // Asynchronous reset between edges, then midscale restart
        cycle(1, 1, 16'h1234, 16'hC000, 0);
        repeat (20) cycle(1, 0, 16'h1234, 16'hC000, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_bs1", 32'(bs1), 0);
        chk("async_rst_cl1", 32'(cl1), 0);
        chk("async_rst_bs2", 32'(bs2), 0);
        chk("async_rst_cl2", 32'(cl2), 0);
        en = 1'b0; sample_valid = 1'b0; clip_clr = 1'b0;
        model_reset();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_mid_pattern("post_rst_pattern");
        repeat (8) cycle(1, 0, 16'h8000, 16'h8000, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dsdac_mod.md
# dsdac_mod

Parametrised multi-channel delta-sigma DAC modulator, successor to the single-channel first-order `dsdac`. It converts `NCH` offset-binary samples, typically from `dds` outputs, into 1-bit density-modulated bitstreams. Each channel runs either a first-order or a second-order loop, with saturating accumulators and a sticky clip flag. The block sits between the signal generators and the output pins, where each bitstream feeds an external RC filter.

## Interface
- `W`, 16: sample width, unsigned offset-binary.
- `NCH`, 2: channel count.
- `ORDER`, 2: loop order; legal values 1 and 2, anything else is an elaboration error.
- `GUARD`, 4: accumulator guard bits; accumulator width `AW = W+GUARD+1` (signed).
- `clk` in 1: sole clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: modulator advance enable.
- `sample_valid` in 1: load strobe for `signal`.
- `signal` in `NCH*W`: channel c occupies bits `[c*W +: W]`.
- `clip_clr` in 1: clears all sticky clip flags.
- `bitstream` out `NCH`: 1-bit modulator outputs, registered.
- `clip` out `NCH`: sticky per-channel saturation flags.

## Operation
- Hold register per channel. Loads `signal` slice on any cycle with `sample_valid`=1, regardless of `en`. Otherwise holds its value (zero-order hold).
- Conversion: `xs = hold - 2^(W-1)`, sign-extended to AW (MSB flip).
- Feedback: `fb = bitstream[c] ? +2^(W-1) : -2^(W-1)`, taken from the registered bit, so there is no combinational loop.
- ORDER=1:
  - `s1 = acc1 + xs - fb`.
  - `acc1 <= sat(s1)`.
  - `bitstream <= (s1 >= 0)`.
- ORDER=2:
  - `s1` as above, then `s2 = acc2 + sat(s1) - fb`.
  - `acc1 <= sat(s1)`, `acc2 <= sat(s2)`.
  - `bitstream <= (s2 >= 0)`.
- `sat()` clamps to `[-2^(AW-1), 2^(AW-1)-1]`. Intermediate sums are computed at AW+2 bits so they never wrap.
- Clip flag:
  - Any clamp in a channel's update sets `clip[c]`.
  - `clip_clr` clears all flags.
  - If a clamp and `clip_clr` occur in the same cycle, set wins.
- `en`=0: `acc1`, `acc2` and `bitstream` freeze; no clamp can occur. `en`=1 resumes from the frozen state.
- Channels are fully independent; all share `en`, `sample_valid` and `clip_clr`.

## Timing
- Reset values:
  - `acc1 = acc2 = 0`.
  - hold registers = `2^(W-1)` (midscale).
  - `bitstream = 0`, `clip = 0`.
- Latency, counting from the edge E at which `sample_valid`=1 is sampled:
  - New sample is in the hold register after E.
  - Its first effect on `acc` and `bitstream` appears at edge E+1.
- One modulator update per enabled clock; the output rate equals the clk rate.
- Reset asserted mid-operation clears state immediately, asynchronously. Release is synchronous to the next `clk` edge; the first update happens on the first edge with `rst_n`=1 and `en`=1.
- `sample_valid` and `en` both high in the same cycle: the update uses the old hold value and the new value is loaded.

## Configuration
- `DSDAC_DITHER_EN` defined:
  - Each channel has a 16-bit Fibonacci LFSR, taps 16,14,13,11, seeded `16'hACE1 ^ c`, stepping every enabled cycle.
  - `s1` gains an extra term `lfsr[0] ? +1 : -1` (±1 LSB).
  - Reset reloads the seed.
- Not defined: no LFSR logic, no dither term. The output is bit-exact to the equations above.

## Structure
- Package `dsdac_pkg` holds:
  - the `sat` function, parametrised by width via a localparam-sized argument;
  - LFSR seed and tap constants;
  - the legal-ORDER check constant.
- Sub-module `dsdac_channel` holds one channel: hold register, integrators, quantiser, clip flag and optional LFSR.
- `dsdac_mod` is a generate loop over `NCH` instances plus bus slicing.

## Test plan
All scenarios run with `DSDAC_DITHER_EN` undefined and W=16.
- Reset check: `rst_n` low, no sample loaded → `bitstream=0`, `clip=0`. After release with `en`=1, midscale input, ORDER=1 → pattern 1,1,0,1,0,1… (alternating after 2 cycles); count 512±1 ones in 1024 cycles.
- ORDER=1, load `16'h4000` → after a 4-cycle transient, exact repeating pattern 1,0,0,0 (25% density).
- ORDER=2, channel 0 = `16'h2000`, channel 1 = `16'hE000` → ones count over 8192 cycles is 1024±8 on channel 0 and 7168±8 on channel 1; no clip.
- ORDER=2, load `16'hFFFF`, run 4096 cycles → `clip[0]` sets and stays set. Pulse `clip_clr` while clamping persists → flag remains 1. Load midscale, wait 64 cycles, pulse `clip_clr` → flag reads 0.
- Freeze: toggle `en`=0 for 100 cycles mid-run → `bitstream` and accumulators unchanged. On resume, the sequence continues identically to a golden model that skipped those cycles.
- Async reset asserted mid-run, between clock edges → outputs go to 0 with no clk edge; hold register reads midscale afterwards.
